// File: rtl/gate_chk_pkg.sv
// Shared FSM state encoding and 2-input truth-table constants for gate_response_checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gate_chk_state_t;

    // Expected y indexed by {a,b}: bit0 = 00 .. bit3 = 11
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_chk_sat_cnt.sv
// CNT_W-wide up counter with synchronous clear and saturation at all-ones.
module gate_chk_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Observer for 2-input gate DUTs: compares sampled y against TRUTH_TABLE over NUM_VEC samples.
// Optional input-pair coverage (cov_mask, gating pass) is enabled by defining GATE_CHK_COVERAGE_EN.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = TT_NAND,
    parameter int         NUM_VEC     = 5,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_vld,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [1:0]       first_err_ab
`ifdef GATE_CHK_COVERAGE_EN
    ,
    output logic [3:0]       cov_mask
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    gate_chk_state_t state, state_nxt;
    logic            accept;
    logic            mismatch;
    logic            all_ok;

    // A start in the same cycle wins over any sample, so that sample is dropped.
    assign accept   = (state == ST_RUN) && sample_vld && !start;
    assign mismatch = (y != TRUTH_TABLE[{a, b}]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (start) begin
                    state_nxt = ST_RUN;
                end else if (accept && (vec_cnt == LAST_IDX)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    gate_chk_sat_cnt #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (accept),
        .cnt (vec_cnt)
    );

    gate_chk_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (accept && mismatch),
        .cnt (err_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_vld <= 1'b0;
            first_err_ab  <= 2'b00;
        end else if (start) begin
            first_err_vld <= 1'b0;
            first_err_ab  <= 2'b00;
        end else if (accept && mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_ab  <= {a, b};
        end
    end

`ifdef GATE_CHK_COVERAGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_mask <= 4'h0;
        end else if (start) begin
            cov_mask <= 4'h0;
        end else if (accept) begin
            cov_mask[{a, b}] <= 1'b1;
        end
    end

    assign all_ok = (err_cnt == '0) && (cov_mask == 4'hF);
`else
    assign all_ok = (err_cnt == '0);
`endif

    // Counters are frozen in DONE, so a combinational pass tracks the final result.
    assign pass = done && all_ok;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker (default NAND table, 5 vectors).
module tb_gate_response_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sample_vld = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       y = 1'b0;
    logic       busy, done, pass, first_err_vld;
    logic [7:0] vec_cnt, err_cnt;
    logic [1:0] first_err_ab;
`ifdef GATE_CHK_COVERAGE_EN
    logic [3:0] cov_mask;
`endif

    int checks = 0;
    int errors = 0;

    gate_response_checker #(
        .TRUTH_TABLE(TT_NAND),
        .NUM_VEC    (5),
        .CNT_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sample_vld    (sample_vld),
        .a             (a),
        .b             (b),
        .y             (y),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .vec_cnt       (vec_cnt),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_ab  (first_err_ab)
`ifdef GATE_CHK_COVERAGE_EN
        ,
        .cov_mask      (cov_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] ab, input logic yv);
        sample_vld = 1'b1;
        {a, b}     = ab;
        y          = yv;
        step();
        sample_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
        checks++; if (vec_cnt !== 8'd0) begin errors++; $display("FAIL reset_vec_cnt: got %0d expected 0", vec_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (first_err_vld !== 1'b0) begin errors++; $display("FAIL reset_first_err_vld: got %b expected 0", first_err_vld); end
        checks++; if (first_err_ab !== 2'b00) begin errors++; $display("FAIL reset_first_err_ab: got %b expected 00", first_err_ab); end
    endtask

    task automatic test_idle_ignore();
        send(2'b11, 1'b1);
        send(2'b00, 1'b0);
        checks++; if (vec_cnt !== 8'd0) begin errors++; $display("FAIL idle_vec_cnt: got %0d expected 0", vec_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL idle_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_nand_pass();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nand_busy: got %b expected 1", busy); end
        send(2'b00, 1'b1);
        checks++; if (vec_cnt !== 8'd1) begin errors++; $display("FAIL nand_vec_cnt_1: got %0d expected 1", vec_cnt); end
        send(2'b01, 1'b1);
        send(2'b10, 1'b1);
        send(2'b11, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nand_done_early: got %b expected 0", done); end
        send(2'b00, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL nand_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nand_busy_end: got %b expected 0", busy); end
        checks++; if (vec_cnt !== 8'd5) begin errors++; $display("FAIL nand_vec_cnt: got %0d expected 5", vec_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL nand_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL nand_pass: got %b expected 1", pass); end
        checks++; if (first_err_vld !== 1'b0) begin errors++; $display("FAIL nand_first_err_vld: got %b expected 0", first_err_vld); end
    endtask

    // AND outputs 0,0,0,1,0 against NAND 1,1,1,0,1: every vector mismatches.
    task automatic test_and_fail();
        pulse_start();
        send(2'b00, 1'b0);
        checks++; if (first_err_ab !== 2'b00 || first_err_vld !== 1'b1) begin errors++; $display("FAIL and_first_capture: got vld=%b ab=%b expected vld=1 ab=00", first_err_vld, first_err_ab); end
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b1);
        send(2'b00, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL and_done: got %b expected 1", done); end
        checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL and_err_cnt: got %0d expected 5", err_cnt); end
        checks++; if (first_err_ab !== 2'b00) begin errors++; $display("FAIL and_first_err_ab: got %b expected 00", first_err_ab); end
        checks++; if (first_err_vld !== 1'b1) begin errors++; $display("FAIL and_first_err_vld: got %b expected 1", first_err_vld); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL and_pass: got %b expected 0", pass); end
    endtask

    task automatic test_done_ignore_restart();
        send(2'b11, 1'b1);
        send(2'b01, 1'b0);
        checks++; if (vec_cnt !== 8'd5) begin errors++; $display("FAIL done_vec_cnt: got %0d expected 5", vec_cnt); end
        checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL done_err_cnt: got %0d expected 5", err_cnt); end
        // start together with a sample: sample must be dropped
        start = 1'b1; sample_vld = 1'b1; {a, b} = 2'b11; y = 1'b1;
        step();
        start = 1'b0; sample_vld = 1'b0;
        checks++; if (vec_cnt !== 8'd0) begin errors++; $display("FAIL restart_vec_cnt: got %0d expected 0", vec_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL restart_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", busy); end
        checks++; if (first_err_vld !== 1'b0) begin errors++; $display("FAIL restart_first_err_vld: got %b expected 0", first_err_vld); end
    endtask

    task automatic test_back_to_back();
        send(2'b10, 1'b0);
        send(2'b01, 1'b0);
        checks++; if (first_err_ab !== 2'b10) begin errors++; $display("FAIL b2b_first_err_ab: got %b expected 10", first_err_ab); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected 2", err_cnt); end
        pulse_start();
        checks++; if (err_cnt !== 8'd0 || vec_cnt !== 8'd0) begin errors++; $display("FAIL b2b_restart_cnts: got vec=%0d err=%0d expected 0 0", vec_cnt, err_cnt); end
        checks++; if (first_err_vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_ctrl: got vld=%b busy=%b expected 0 1", first_err_vld, busy); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++; if (vec_cnt !== 8'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_cnts: got vec=%0d err=%0d expected 0 0", vec_cnt, err_cnt); end
        checks++; if (busy !== 1'b0 || first_err_vld !== 1'b0 || first_err_ab !== 2'b00) begin errors++; $display("FAIL async_rst_ctrl: got busy=%b vld=%b ab=%b expected 0 0 00", busy, first_err_vld, first_err_ab); end
        step();
        rst = 1'b0;
        step();
        pulse_start();
        send(2'b00, 1'b1);
        send(2'b01, 1'b1);
        send(2'b10, 1'b1);
        send(2'b11, 1'b0);
        send(2'b11, 1'b0);
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL post_rst_run: got done=%b pass=%b expected 1 1", done, pass); end
        checks++; if (vec_cnt !== 8'd5 || err_cnt !== 8'd0) begin errors++; $display("FAIL post_rst_cnts: got vec=%0d err=%0d expected 5 0", vec_cnt, err_cnt); end
    endtask

`ifdef GATE_CHK_COVERAGE_EN
    task automatic test_coverage();
        pulse_start();
        checks++; if (cov_mask !== 4'h0) begin errors++; $display("FAIL cov_clear: got %b expected 0000", cov_mask); end
        repeat (5) send(2'b00, 1'b1);
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL cov_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (cov_mask !== 4'b0001) begin errors++; $display("FAIL cov_mask: got %b expected 0001", cov_mask); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL cov_pass: got done=%b pass=%b expected 1 0", done, pass); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ignore();
        test_nand_pass();
        test_and_fail();
        test_done_ignore_restart();
        test_back_to_back();
        test_async_reset();
`ifdef GATE_CHK_COVERAGE_EN
        test_coverage();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
